reg_stage_fifo: RTL and testbench

- Small circular-buffer FIFO that sits directly upstream of the pipeline data register in the TABLA datapath.
- Absorbs bursty writes from the producer.
- Drains one word per pop into the register: dataOut connects to the register's dataIn, outValid connects to its wrEn.
- Reports occupancy and sticky overflow/underflow errors for debug.

---
 rtl/reg_stage_fifo.sv | 122 ++++++++++++
 tb/tb_reg_stage_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reg_stage_fifo.sv
// reg_stage_fifo: small circular-buffer FIFO that feeds the TABLA pipeline
// data register. dataOut/outValid drive the register's dataIn/wrEn directly.
// Occupancy is reported through count/full/empty. Sticky overflow and
// underflow flags record rejected pushes and pops for debug.
module reg_stage_fifo #(
    parameter int LEN    = 9,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [LEN-1:0]    dataIn,
    input  logic              pop,
    output logic [LEN-1:0]    dataOut,
    output logic              outValid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int CNT_W = ADDR_W + 1;

    logic [LEN-1:0]    mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [LEN-1:0]    data_out_r;
    logic              out_valid_r;
    logic              overflow_r;
    logic              underflow_r;

    logic              full_s;
    logic              empty_s;
    logic              pop_ok_s;
    logic              push_ok_s;
    logic [CNT_W-1:0]  count_nxt_s;

    // Occupancy decode and acceptance of push/pop for this cycle
    always_comb begin
        full_s    = (count_r == CNT_W'(DEPTH));
        empty_s   = (count_r == {CNT_W{1'b0}});
        pop_ok_s  = pop & ~empty_s;
        // A full FIFO still takes a write when a read frees a slot on the same edge
        push_ok_s = push & (~full_s | pop_ok_s);
    end

    // Next occupancy: +1 push-only, -1 pop-only, otherwise unchanged
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            2'b11:   count_nxt_s = count_r;
            2'b00:   count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= dataIn;
        end
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Registered read port; reading the old entry on a same-address write falls out of NBA ordering
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_r  <= {LEN{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= pop_ok_s;
            if (pop_ok_s) begin
                data_out_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push && !push_ok_s) begin
                overflow_r <= 1'b1;
            end
            if (pop && !pop_ok_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign dataOut   = data_out_r;
    assign outValid  = out_valid_r;
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_reg_stage_fifo.sv
// Directed testbench for reg_stage_fifo with hand-computed expectations.
module tb_reg_stage_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic [8:0] dataIn;
    logic       pop;
    logic [8:0] dataOut;
    logic       outValid;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;
    logic [8:0] cap_reg;

    reg_stage_fifo #(.LEN(9), .DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .push(push), .dataIn(dataIn), .pop(pop),
        .dataOut(dataOut), .outValid(outValid), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream pipeline register fed by the FIFO
    always @(posedge clk) begin
        if (outValid) cap_reg <= dataOut;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, then sample 1 time unit later
    task automatic cyc(input logic ps, input logic [8:0] d, input logic pp);
        push = ps; dataIn = d; pop = pp;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; dataIn = 9'h000;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        cyc(1'b0, 9'h000, 1'b0);
        cyc(1'b0, 9'h000, 1'b0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_valid", 32'(outValid), 32'd0);
        check_eq("rst_data", 32'(dataOut), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_unf", 32'(underflow), 32'd0);

        // Order and latency
        cyc(1'b1, 9'h011, 1'b0); check_eq("ord_cnt1", 32'(count), 32'd1);
        cyc(1'b1, 9'h022, 1'b0); check_eq("ord_cnt2", 32'(count), 32'd2);
        cyc(1'b1, 9'h033, 1'b0); check_eq("ord_cnt3", 32'(count), 32'd3);
        cyc(1'b0, 9'h000, 1'b1);
        check_eq("ord_cnt_p1", 32'(count), 32'd2);
        check_eq("ord_v1", 32'(outValid), 32'd1);
        check_eq("ord_d1", 32'(dataOut), 32'h011);
        cyc(1'b0, 9'h000, 1'b1);
        check_eq("ord_cnt_p2", 32'(count), 32'd1);
        check_eq("ord_v2", 32'(outValid), 32'd1);
        check_eq("ord_d2", 32'(dataOut), 32'h022);
        check_eq("ord_cap1", 32'(cap_reg), 32'h011);
        cyc(1'b0, 9'h000, 1'b1);
        check_eq("ord_cnt_p3", 32'(count), 32'd0);
        check_eq("ord_v3", 32'(outValid), 32'd1);
        check_eq("ord_d3", 32'(dataOut), 32'h033);
        check_eq("ord_empty", 32'(empty), 32'd1);
        cyc(1'b0, 9'h000, 1'b0);
        check_eq("ord_idle_v", 32'(outValid), 32'd0);
        check_eq("ord_hold_d", 32'(dataOut), 32'h033);
        check_eq("ord_cap3", 32'(cap_reg), 32'h033);

        // Full and overflow
        do_reset();
        for (int i = 1; i <= 4; i++) cyc(1'b1, 9'(i), 1'b0);
        check_eq("full_flag", 32'(full), 32'd1);
        check_eq("full_cnt", 32'(count), 32'd4);
        check_eq("full_ovf0", 32'(overflow), 32'd0);
        cyc(1'b1, 9'h005, 1'b0);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_cnt", 32'(count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 9'h000, 1'b1);
            check_eq("ovf_drain_d", 32'(dataOut), 32'(i));
            check_eq("ovf_drain_v", 32'(outValid), 32'd1);
        end
        check_eq("ovf_drain_empty", 32'(empty), 32'd1);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);

        // Wrap with simultaneous push/pop while full
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 9'h0A0 + 9'(i), 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 9'h0B0 + 9'(i), 1'b1);
            check_eq("wrap_cnt", 32'(count), 32'd4);
            check_eq("wrap_v", 32'(outValid), 32'd1);
            check_eq("wrap_d", 32'(dataOut), (i < 4) ? 32'h0A0 + 32'(i) : 32'h0B0 + 32'(i - 4));
        end
        check_eq("wrap_ovf", 32'(overflow), 32'd0);
        for (int i = 2; i < 6; i++) begin
            cyc(1'b0, 9'h000, 1'b1);
            check_eq("wrap_drain_d", 32'(dataOut), 32'h0B0 + 32'(i));
        end
        check_eq("wrap_drain_cnt", 32'(count), 32'd0);

        // Empty edge cases
        do_reset();
        cyc(1'b0, 9'h000, 1'b1);
        check_eq("emp_unf", 32'(underflow), 32'd1);
        check_eq("emp_v", 32'(outValid), 32'd0);
        check_eq("emp_cnt", 32'(count), 32'd0);
        cyc(1'b1, 9'h1FF, 1'b1);
        check_eq("emp_pp_cnt", 32'(count), 32'd1);
        check_eq("emp_pp_v", 32'(outValid), 32'd0);
        check_eq("emp_pp_empty", 32'(empty), 32'd0);
        cyc(1'b0, 9'h000, 1'b1);
        check_eq("emp_pop_d", 32'(dataOut), 32'h1FF);
        check_eq("emp_pop_v", 32'(outValid), 32'd1);
        check_eq("emp_pop_cnt", 32'(count), 32'd0);

        // Asynchronous reset mid-burst
        do_reset();
        for (int i = 1; i <= 4; i++) cyc(1'b1, 9'h100 + 9'(i), 1'b0);
        cyc(1'b0, 9'h000, 1'b1);
        check_eq("ar_pre_cnt", 32'(count), 32'd3);
        check_eq("ar_pre_v", 32'(outValid), 32'd1);
        check_eq("ar_pre_d", 32'(dataOut), 32'h101);
        #2 reset = 1'b0;
        #1;
        check_eq("ar_cnt", 32'(count), 32'd0);
        check_eq("ar_v", 32'(outValid), 32'd0);
        check_eq("ar_d", 32'(dataOut), 32'd0);
        check_eq("ar_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(1'b0, 9'h000, 1'b0);
        check_eq("ar_idle_v", 32'(outValid), 32'd0);
        cyc(1'b0, 9'h000, 1'b1);
        check_eq("ar_pop_unf", 32'(underflow), 32'd1);
        check_eq("ar_pop_v", 32'(outValid), 32'd0);
        check_eq("ar_pop_cnt", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
